// File: rtl/rv_pkg.sv
// Shared RV32I fetch definitions: opcodes, 2-bit predictor counter states, immediate
// decode and saturating counter helpers used by the fetch stage and its predictor.
package rv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, execute feedback (redirect/training)
// and the IF/ID register outputs. master = fetch stage, slave = its surroundings.
interface fetch_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_counter;
  logic        upd_taken;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [1:0]  counter_out;
  logic        branch_prediction_out;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_counter, upd_taken,
    output valid_out, pc_out, instr_out, counter_out, branch_prediction_out
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_counter, upd_taken,
    input  valid_out, pc_out, instr_out, counter_out, branch_prediction_out
  );

endinterface

// File: rtl/bht_bimodal.sv
// Bimodal table of 2-bit counters: combinational read, write lands at the clock edge
// (a same-index read in the write cycle sees the old value). Sync reset to INIT.
module bht_bimodal #(
  parameter int         BHT_IDX_BITS = 6,
  parameter logic [1:0] BHT_INIT     = 2'b01
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BHT_IDX_BITS-1:0] rd_idx,
  output logic [1:0]              rd_cnt,
  input  logic                    wr_en,
  input  logic [BHT_IDX_BITS-1:0] wr_idx,
  input  logic [1:0]              wr_cnt
);

  localparam int ENTRIES = 1 << BHT_IDX_BITS;

  logic [1:0] mem [ENTRIES];

  assign rd_cnt = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= BHT_INIT;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_cnt;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with bimodal branch/JAL prediction and the IF/ID register.
// One edge from PC to IF/ID outputs; stg_ena=0 holds everything, redirect overrides stall.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BHT_IDX_BITS = 6,
  parameter logic [1:0]  BHT_INIT     = WNT
) (
  input  logic          stg_clk,
  input  logic          reset,
  input  logic          stg_ena,
  fetch_stage_if.master bus
);

  logic [31:0] pc_reg;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        is_br;
  logic        is_jal;
  logic        pred;
  logic [1:0]  cnt;
  logic [1:0]  upd_next;

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [1:0]  cnt_q;
  logic        pred_q;

  // Address bits outside the table index and the byte offsets carry no information here.
  logic unused_ok;
  assign unused_ok = ^{bus.upd_pc[31:BHT_IDX_BITS+2], bus.upd_pc[1:0], bus.redirect_pc[1:0]};

  assign instr  = bus.imem_data;
  assign opcode = instr[6:0];
  assign is_br  = (opcode == OPC_BRANCH);
  assign is_jal = (opcode == OPC_JAL);
  assign pred   = is_jal | (is_br & cnt[1]);

  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (is_jal) begin
      next_pc = pc_reg + imm_j(instr);
    end else if (is_br && cnt[1]) begin
      next_pc = pc_reg + imm_b(instr);
    end
  end

  assign upd_next = bus.upd_taken ? sat_inc(bus.upd_counter) : sat_dec(bus.upd_counter);

  bht_bimodal #(
    .BHT_IDX_BITS (BHT_IDX_BITS),
    .BHT_INIT     (BHT_INIT)
  ) u_bht (
    .clk    (stg_clk),
    .reset  (reset),
    .rd_idx (pc_reg[BHT_IDX_BITS+1:2]),
    .rd_cnt (cnt),
    .wr_en  (bus.upd_valid),
    .wr_idx (bus.upd_pc[BHT_IDX_BITS+1:2]),
    .wr_cnt (upd_next)
  );

  // A redirect only kills the IF/ID entry; its other fields stay as they were.
  always_ff @(posedge stg_clk) begin
    if (reset) begin
      pc_reg  <= RESET_PC;
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      cnt_q   <= 2'b00;
      pred_q  <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_reg  <= {bus.redirect_pc[31:2], 2'b00};
      valid_q <= 1'b0;
    end else if (stg_ena) begin
      pc_reg  <= next_pc;
      valid_q <= 1'b1;
      pc_q    <= pc_reg;
      instr_q <= instr;
      cnt_q   <= cnt;
      pred_q  <= pred;
    end
  end

  assign bus.imem_addr             = pc_reg;
  assign bus.valid_out             = valid_q;
  assign bus.pc_out                = pc_q;
  assign bus.instr_out             = instr_q;
  assign bus.counter_out           = cnt_q;
  assign bus.branch_prediction_out = pred_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed fetch streams push expected IF/ID entries,
// a negedge monitor pops and compares every entry produced by an advancing edge.
module tb_fetch_stage;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] BEQ  = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] JAL  = 32'hFF9F_F06F;  // jal x0,-8

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  cnt;
    logic        pred;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic stg_ena;
  logic last_adv = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [31:0] imem_mem [256];

  fetch_stage_if ifc ();

  fetch_stage dut (
    .stg_clk (clk),
    .reset   (reset),
    .stg_ena (stg_ena),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  always_comb ifc.imem_data = imem_mem[ifc.imem_addr[9:2]];

  always @(posedge clk) last_adv <= !reset && !ifc.redirect_valid && stg_ena;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (last_adv) begin
      exp_t e;
      chk("valid_after_adv", {31'd0, ifc.valid_out}, 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_entry: got pc %h with empty scoreboard", ifc.pc_out);
      end else begin
        e = exp_q.pop_front();
        chk("pc_out", ifc.pc_out, e.pc);
        chk("instr_out", ifc.instr_out, e.instr);
        chk("counter_out", {30'd0, ifc.counter_out}, {30'd0, e.cnt});
        chk("pred_out", {31'd0, ifc.branch_prediction_out}, {31'd0, e.pred});
      end
    end
  end

  task automatic adv(input logic [31:0] pc, input logic [31:0] ins,
                     input logic [1:0] cnt, input logic pred);
    exp_t e;
    e.pc = pc; e.instr = ins; e.cnt = cnt; e.pred = pred;
    exp_q.push_back(e);
    stg_ena = 1'b1;
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    stg_ena = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = pc;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, ifc.valid_out}, 32'd0);
    chk({tag, "_pc_out"}, ifc.pc_out, 32'd0);
    chk({tag, "_instr_out"}, ifc.instr_out, 32'd0);
    chk({tag, "_counter_out"}, {30'd0, ifc.counter_out}, 32'd0);
    chk({tag, "_pred"}, {31'd0, ifc.branch_prediction_out}, 32'd0);
    chk({tag, "_imem_addr"}, ifc.imem_addr, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem_mem[i] = ADDI;
    imem_mem[8'h08 >> 2] = BEQ;
    imem_mem[8'h20 >> 2] = JAL;

    reset = 1'b1;
    stg_ena = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 32'd0;
    ifc.upd_valid = 1'b0;
    ifc.upd_pc = 32'd0;
    ifc.upd_counter = 2'b00;
    ifc.upd_taken = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");

    // Untrained stream: BEQ at 8 sees weakly-not-taken and falls through.
    reset = 1'b0;
    adv(32'h00, ADDI, 2'b01, 1'b0);
    adv(32'h04, ADDI, 2'b01, 1'b0);
    adv(32'h08, BEQ,  2'b01, 1'b0);
    adv(32'h0C, ADDI, 2'b01, 1'b0);

    // Train entry 2 to weakly-taken while redirecting back to 0.
    ifc.upd_valid = 1'b1;
    ifc.upd_pc = 32'h08;
    ifc.upd_counter = 2'b01;
    ifc.upd_taken = 1'b1;
    redirect_to(32'h0);
    ifc.upd_valid = 1'b0;
    chk("redirect_kill", {31'd0, ifc.valid_out}, 32'd0);
    chk("redirect_addr", ifc.imem_addr, 32'h0);

    adv(32'h00, ADDI, 2'b01, 1'b0);
    adv(32'h04, ADDI, 2'b01, 1'b0);
    adv(32'h08, BEQ,  2'b10, 1'b1);
    adv(32'h18, ADDI, 2'b01, 1'b0);
    adv(32'h1C, ADDI, 2'b01, 1'b0);
    adv(32'h20, JAL,  2'b01, 1'b1);
    adv(32'h18, ADDI, 2'b01, 1'b0);

    // Redirect during stall with a misaligned target.
    redirect_to(32'h103);
    chk("redir_stall_kill", {31'd0, ifc.valid_out}, 32'd0);
    chk("redir_stall_pc_hold", ifc.pc_out, 32'h18);
    chk("redir_align", ifc.imem_addr, 32'h100);
    adv(32'h100, ADDI, 2'b01, 1'b0);

    // Saturation at strongly-taken on entry 1.
    stg_ena = 1'b0;
    ifc.upd_valid = 1'b1;
    ifc.upd_pc = 32'h04;
    ifc.upd_counter = 2'b11;
    ifc.upd_taken = 1'b1;
    repeat (4) @(negedge clk);
    ifc.upd_valid = 1'b0;
    redirect_to(32'h04);
    // Read old 11 while writing not-taken from 00 in the same cycle.
    ifc.upd_valid = 1'b1;
    ifc.upd_counter = 2'b00;
    ifc.upd_taken = 1'b0;
    adv(32'h04, ADDI, 2'b11, 1'b0);
    ifc.upd_valid = 1'b0;
    redirect_to(32'h04);
    adv(32'h04, ADDI, 2'b00, 1'b0);
    adv(32'h08, BEQ,  2'b10, 1'b1);

    // Stall holds the entry and the PC.
    for (int s = 0; s < 3; s++) begin
      stg_ena = 1'b0;
      @(negedge clk);
      chk("stall_valid", {31'd0, ifc.valid_out}, 32'd1);
      chk("stall_pc_out", ifc.pc_out, 32'h08);
      chk("stall_instr", ifc.instr_out, BEQ);
      chk("stall_cnt", {30'd0, ifc.counter_out}, 32'd2);
      chk("stall_pred", {31'd0, ifc.branch_prediction_out}, 32'd1);
      chk("stall_addr", ifc.imem_addr, 32'h18);
    end

    // Reset during stall with a redirect pending: reset wins.
    reset = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h40;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    chk_reset_state("rst2");
    reset = 1'b0;
    adv(32'h00, ADDI, 2'b01, 1'b0);
    adv(32'h04, ADDI, 2'b01, 1'b0);
    adv(32'h08, BEQ,  2'b01, 1'b0);

    stg_ena = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
